// File: rtl/debouncer_bank_if.sv
// Signal bundle between raw board inputs / consumers and the debouncer bank.
// The master drives the raw inputs and the tick enable; the slave is the bank.
interface debouncer_bank_if #(
  parameter int unsigned N_CH = 4
);
  logic            tick_en;
  logic [N_CH-1:0] bouncy_in;
  logic [N_CH-1:0] debounced_out;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic [N_CH-1:0] held;

  modport master (
    output tick_en,
    output bouncy_in,
    input  debounced_out,
    input  rise,
    input  fall,
    input  held
  );

  modport slave (
    input  tick_en,
    input  bouncy_in,
    output debounced_out,
    output rise,
    output fall,
    output held
  );
endinterface

// File: rtl/debouncer_bank.sv
// Bank of independent debouncers: per-channel synchronizer, four-state debounce FSM,
// clean level, one-cycle rise/fall pulses and an optional long-press pulse.
module debouncer_bank #(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned BOUNCE_TICKS = 10,
  parameter int unsigned HOLD_TICKS   = 0
) (
  input logic              clk,
  input logic              rst,
  debouncer_bank_if.slave  bus
);

  localparam int unsigned DW = $clog2(BOUNCE_TICKS) + 1;
  localparam int unsigned HW = $clog2(HOLD_TICKS) + 1;
  localparam logic [DW-1:0] BOUNCE_LAST = DW'(BOUNCE_TICKS - 1);
  localparam logic [HW-1:0] HOLD_MAX    = HW'(HOLD_TICKS);
  localparam logic [HW-1:0] HOLD_LAST   = HW'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);
  localparam bit            HOLD_EN     = (HOLD_TICKS > 0);

  typedef enum logic [1:0] {
    S_0       = 2'd0,
    S_MAYBE_1 = 2'd1,
    S_1       = 2'd2,
    S_MAYBE_0 = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q  [N_CH];
  state_t                 state_q [N_CH];
  logic [DW-1:0]          db_cnt_q  [N_CH];
  logic [HW-1:0]          hold_cnt_q[N_CH];
  logic [N_CH-1:0]        level_q;
  logic [N_CH-1:0]        rise_q;
  logic [N_CH-1:0]        fall_q;
  logic [N_CH-1:0]        held_q;

  // Synchronizers, debounce FSMs and registered pulse outputs for every channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      held_q  <= '0;
      for (int c = 0; c < N_CH; c++) begin
        sync_q[c]     <= '0;
        state_q[c]    <= S_0;
        db_cnt_q[c]   <= '0;
        hold_cnt_q[c] <= '0;
      end
    end else begin
      rise_q <= '0;
      fall_q <= '0;
      held_q <= '0;
      for (int c = 0; c < N_CH; c++) begin
        sync_q[c] <= {sync_q[c][SYNC_STAGES-2:0], bus.bouncy_in[c]};
        case (state_q[c])
          S_0: begin
            if (sync_q[c][SYNC_STAGES-1]) begin
              state_q[c]  <= S_MAYBE_1;
              db_cnt_q[c] <= '0;
            end
          end
          S_MAYBE_1: begin
            if (!sync_q[c][SYNC_STAGES-1]) begin
              state_q[c] <= S_0;
            end else if (bus.tick_en) begin
              if (db_cnt_q[c] == BOUNCE_LAST) begin
                state_q[c]    <= S_1;
                level_q[c]    <= 1'b1;
                rise_q[c]     <= 1'b1;
                hold_cnt_q[c] <= '0;
              end else begin
                db_cnt_q[c] <= db_cnt_q[c] + DW'(1);
              end
            end
          end
          S_1: begin
            if (!sync_q[c][SYNC_STAGES-1]) begin
              state_q[c]    <= S_MAYBE_0;
              db_cnt_q[c]   <= '0;
              hold_cnt_q[c] <= '0;
            end else if (HOLD_EN && bus.tick_en && (hold_cnt_q[c] != HOLD_MAX)) begin
              // Saturating at HOLD_MAX keeps held to a single pulse per press.
              hold_cnt_q[c] <= hold_cnt_q[c] + HW'(1);
              if (hold_cnt_q[c] == HOLD_LAST) held_q[c] <= 1'b1;
            end
          end
          S_MAYBE_0: begin
            if (sync_q[c][SYNC_STAGES-1]) begin
              state_q[c] <= S_1;
            end else if (bus.tick_en) begin
              if (db_cnt_q[c] == BOUNCE_LAST) begin
                state_q[c] <= S_0;
                level_q[c] <= 1'b0;
                fall_q[c]  <= 1'b1;
              end else begin
                db_cnt_q[c] <= db_cnt_q[c] + DW'(1);
              end
            end
          end
          default: begin
            state_q[c]    <= S_0;
            level_q[c]    <= 1'b0;
            db_cnt_q[c]   <= '0;
            hold_cnt_q[c] <= '0;
          end
        endcase
      end
    end
  end

  assign bus.debounced_out = level_q;
  assign bus.rise          = rise_q;
  assign bus.fall          = fall_q;
  assign bus.held          = held_q;

endmodule

// File: tb/tb_debouncer_bank.sv
// Scoreboard bench for debouncer_bank: two instances (held disabled / HOLD_TICKS=50),
// expected pulses queued with their edge number as stimulus is driven.
module tb_debouncer_bank;
  localparam int unsigned NC     = 4;
  localparam int unsigned LAT    = 12;
  localparam int unsigned HOLD_B = 50;

  typedef struct {
    int unsigned cyc;
    int          d;
    int          k;
    int          c;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail  = 0;
  ev_t         exq[$];
  logic [NC-1:0] pulses [6];

  debouncer_bank_if #(.N_CH(NC)) bus_a ();
  debouncer_bank_if #(.N_CH(NC)) bus_b ();

  debouncer_bank #(.N_CH(NC), .SYNC_STAGES(2), .BOUNCE_TICKS(10), .HOLD_TICKS(0))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  debouncer_bank #(.N_CH(NC), .SYNC_STAGES(2), .BOUNCE_TICKS(10), .HOLD_TICKS(HOLD_B))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign pulses[0] = bus_a.rise;
  assign pulses[1] = bus_a.fall;
  assign pulses[2] = bus_a.held;
  assign pulses[3] = bus_b.rise;
  assign pulses[4] = bus_b.fall;
  assign pulses[5] = bus_b.held;

  function automatic string kname(int k);
    case (k)
      0:       return "rise";
      1:       return "fall";
      default: return "held";
    endcase
  endfunction

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_ev(int unsigned at, int d, int k, int c);
    ev_t e;
    e.cyc = at; e.d = d; e.k = k; e.c = c;
    exq.push_back(e);
  endtask

  // Sampled at negedge: every observed pulse must pop a queued expectation for this edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 3; k++) begin
        for (int c = 0; c < NC; c++) begin
          logic [NC-1:0] v;
          int idx;
          v = pulses[d*3+k];
          if (v[c] === 1'b1) begin
            idx = -1;
            for (int i = 0; i < exq.size(); i++)
              if (idx < 0 && exq[i].cyc == cyc && exq[i].d == d && exq[i].k == k && exq[i].c == c)
                idx = i;
            n_tests++;
            if (idx < 0) begin
              n_fail++;
              $display("FAIL %s dut%0d ch%0d: got pulse at edge %0d, required none", kname(k), d, c, cyc);
            end else begin
              exq.delete(idx);
            end
          end
        end
      end
    end
    for (int i = exq.size() - 1; i >= 0; i--) begin
      if (exq[i].cyc <= cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s dut%0d ch%0d: got no pulse, required pulse at edge %0d",
                 kname(exq[i].k), exq[i].d, exq[i].c, exq[i].cyc);
        exq.delete(i);
      end
    end
  end

  task automatic test_reset();
    int unsigned e;
    bus_a.tick_en = 1'b1; bus_b.tick_en = 1'b1;
    bus_a.bouncy_in = 4'hF; bus_b.bouncy_in = 4'hF;
    rst = 1'b1;
    step(1);
    n_tests++;
    if ({bus_a.debounced_out, bus_a.rise, bus_a.fall, bus_a.held} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_a: got %h, required 0", {bus_a.debounced_out, bus_a.rise, bus_a.fall, bus_a.held});
    end
    step(2);
    n_tests++;
    if ({bus_b.debounced_out, bus_b.rise, bus_b.fall, bus_b.held} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_b: got %h, required 0", {bus_b.debounced_out, bus_b.rise, bus_b.fall, bus_b.held});
    end
    rst = 1'b0;
    e = cyc + 1;
    for (int c = 0; c < NC; c++) begin
      expect_ev(e + LAT, 0, 0, c);
      expect_ev(e + LAT, 1, 0, c);
      expect_ev(e + LAT + HOLD_B, 1, 2, c);
    end
    step(LAT - 1);
    n_tests++;
    if (bus_a.debounced_out !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_early_level: got %h, required 0", bus_a.debounced_out);
    end
    step(3);
    n_tests++;
    if (bus_a.debounced_out !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_level: got %h, required f", bus_a.debounced_out);
    end
    step(HOLD_B + 2);
    bus_b.bouncy_in = 4'h0;
    e = cyc + 1;
    for (int c = 0; c < NC; c++) expect_ev(e + LAT, 1, 1, c);
    step(LAT + 2);
    n_tests++;
    if (bus_b.debounced_out !== 4'h0) begin
      n_fail++;
      $display("FAIL release_b_level: got %h, required 0", bus_b.debounced_out);
    end
  endtask

  task automatic test_clean_press();
    int unsigned e;
    bus_a.bouncy_in = 4'b1000;
    e = cyc + 1;
    for (int c = 0; c < 3; c++) expect_ev(e + LAT, 0, 1, c);
    step(LAT + 2);
    bus_a.bouncy_in[0] = 1'b1;
    e = cyc + 1;
    expect_ev(e + LAT, 0, 0, 0);
    step(LAT);
    n_tests++;
    if (bus_a.debounced_out[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL press_edge_minus1: got %b, required 0", bus_a.debounced_out[0]);
    end
    step(1);
    n_tests++;
    if (bus_a.debounced_out[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL press_edge: got %b, required 1", bus_a.debounced_out[0]);
    end
    step(40 - LAT - 1);
    bus_a.bouncy_in[0] = 1'b0;
    e = cyc + 1;
    expect_ev(e + LAT, 0, 1, 0);
    step(LAT);
    n_tests++;
    if (bus_a.debounced_out[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL release_edge_minus1: got %b, required 1", bus_a.debounced_out[0]);
    end
    step(1);
    n_tests++;
    if (bus_a.debounced_out[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL release_edge: got %b, required 0", bus_a.debounced_out[0]);
    end
    step(2);
  endtask

  task automatic test_bounce();
    int unsigned e;
    for (int i = 0; i < 10; i++) begin
      bus_a.bouncy_in[1] = (i % 2 == 0);
      step(3);
    end
    n_tests++;
    if (bus_a.debounced_out[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_level: got %b, required 0", bus_a.debounced_out[1]);
    end
    bus_a.bouncy_in[1] = 1'b1;
    e = cyc + 1;
    expect_ev(e + LAT, 0, 0, 1);
    step(LAT + 4);
    n_tests++;
    if (bus_a.debounced_out[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL bounce_settled: got %b, required 1", bus_a.debounced_out[1]);
    end
  endtask

  task automatic test_independence();
    int unsigned e;
    bus_a.bouncy_in = 4'b0110;
    e = cyc + 1;
    expect_ev(e + LAT, 0, 0, 2);
    expect_ev(e + LAT, 0, 1, 3);
    step(LAT + 2);
    n_tests++;
    if (bus_a.debounced_out !== 4'b0110) begin
      n_fail++;
      $display("FAIL independence_level: got %b, required 0110", bus_a.debounced_out);
    end
  endtask

  task automatic run_gated(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus_a.tick_en = (cyc % 4 == 0);
    end
  endtask

  task automatic test_tick_gating();
    int unsigned e;
    int unsigned n;
    int          ticks;
    bus_a.tick_en = (cyc % 4 == 0);
    bus_a.bouncy_in[0] = 1'b1;
    run_gated(20);
    bus_a.bouncy_in[0] = 1'b0;
    run_gated(12);
    n_tests++;
    if (bus_a.debounced_out[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL gated_short_pulse: got %b, required 0", bus_a.debounced_out[0]);
    end
    bus_a.bouncy_in[0] = 1'b1;
    e = cyc + 1;
    // MAYBE entered at edge e+2; an edge m counts when tick_en was set after edge m-1.
    n = e + 2;
    ticks = 0;
    while (ticks < 10) begin
      n++;
      if ((n - 1) % 4 == 0) ticks++;
    end
    expect_ev(n, 0, 0, 0);
    run_gated(int'(n - 1 - cyc));
    n_tests++;
    if (bus_a.debounced_out[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL gated_edge_minus1: got %b, required 0", bus_a.debounced_out[0]);
    end
    run_gated(1);
    n_tests++;
    if (bus_a.debounced_out[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL gated_commit: got %b at edge %0d, required 1", bus_a.debounced_out[0], cyc);
    end
    n_tests++;
    if (n - e < 38 || n - e > 46) begin
      n_fail++;
      $display("FAIL gated_latency: got %0d, required about 40", n - e);
    end
    bus_a.tick_en = 1'b1;
    step(2);
  endtask

  task automatic test_long_press();
    int unsigned e;
    bus_b.bouncy_in[0] = 1'b1;
    e = cyc + 1;
    expect_ev(e + LAT, 1, 0, 0);
    expect_ev(e + LAT + HOLD_B, 1, 2, 0);
    step(200);
    bus_b.bouncy_in[0] = 1'b0;
    e = cyc + 1;
    expect_ev(e + LAT, 1, 1, 0);
    step(LAT + 2);
    bus_b.bouncy_in[0] = 1'b1;
    e = cyc + 1;
    expect_ev(e + LAT, 1, 0, 0);
    step(30);
    bus_b.bouncy_in[0] = 1'b0;
    step(5);
    bus_b.bouncy_in[0] = 1'b1;
    e = cyc + 1;
    expect_ev(e + 2 + HOLD_B, 1, 2, 0);
    step(20);
    n_tests++;
    if (bus_b.debounced_out[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL dropout_level: got %b, required 1", bus_b.debounced_out[0]);
    end
    step(HOLD_B + 10);
    bus_b.bouncy_in[0] = 1'b0;
    e = cyc + 1;
    expect_ev(e + LAT, 1, 1, 0);
    step(LAT + 2);
    n_tests++;
    if (bus_b.debounced_out[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL long_release_level: got %b, required 0", bus_b.debounced_out[0]);
    end
  endtask

  initial begin
    bus_a.tick_en = 1'b1;
    bus_b.tick_en = 1'b1;
    bus_a.bouncy_in = '0;
    bus_b.bouncy_in = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_independence();
    test_tick_gating();
    test_long_press();
    step(3);
    n_tests++;
    if (exq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
